// File: rtl/sr_flipflop_driver.sv
// Drives an external SR flip-flop from a FIFO of target Q bits and checks q one cycle after each drive.
// Build option: define SR_FORCE_EXCITE_EN to drive redundant excitation on hold transitions.
module sr_flipflop_driver #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    output logic             s,
    output logic             r,
    input  logic             q_fb,
    output logic             busy,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
`ifdef SR_FORCE_EXCITE_EN
    localparam logic FORCE_EXCITE = 1'b1;
`else
    localparam logic FORCE_EXCITE = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_e;

    state_e             state_q;
    logic [DEPTH-1:0]   mem_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               exp_q;
    logic               cur_q;
    logic               cur_d;
    logic               s_q;
    logic               r_q;
    logic               mismatch_q;
    logic [ERR_W-1:0]   err_q;

    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               head_bit;
    logic               check_fail;
    logic               do_excite;
    logic [1:0]         excite;

    assign fifo_empty = (count_q == '0);
    assign tgt_ready  = (count_q != FULL_CNT);
    assign push       = tgt_valid && tgt_ready;
    assign pop        = !fifo_empty && ((state_q == IDLE) || (state_q == CHECK));
    assign head_bit   = mem_q[rd_ptr_q];
    assign check_fail = (q_fb != exp_q);

    // Model state as it will be after this edge; excitation for a pop out of CHECK must see it.
    assign cur_d = (state_q == CHECK) ? (check_fail ? q_fb : exp_q) : cur_q;

    // Set toward 1, reset toward 0; both high is unreachable by construction.
    assign do_excite = FORCE_EXCITE || (cur_d != head_bit);
    assign excite    = do_excite ? (head_bit ? 2'b10 : 2'b01) : 2'b00;

    assign s        = s_q;
    assign r        = r_q;
    assign mismatch = mismatch_q;
    assign err_cnt  = err_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;

    // Target-bit FIFO; a push is never accepted while full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= tgt_bit;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Drive/check sequencer with registered s/r and mismatch outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            exp_q      <= 1'b0;
            cur_q      <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            mismatch_q <= 1'b0;
            cur_q      <= cur_d;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        exp_q      <= head_bit;
                        {s_q, r_q} <= excite;
                        state_q    <= DRIVE;
                    end
                end
                DRIVE: begin
                    state_q <= CHECK;
                end
                CHECK: begin
                    if (check_fail) begin
                        mismatch_q <= 1'b1;
                        if (err_q != ERR_MAX) begin
                            err_q <= err_q + ERR_W'(1);
                        end
                    end
                    if (pop) begin
                        exp_q      <= head_bit;
                        {s_q, r_q} <= excite;
                        state_q    <= DRIVE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_flipflop_driver.sv
// Scoreboard bench for sr_flipflop_driver: a transaction-level model predicts drive timing, excitation and error count.
module tb_sr_flipflop_driver;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned ERR_W = 8;
    localparam int          ERR_MAX = (1 << ERR_W) - 1;

    logic             clk;
    logic             rst;
    logic             tgt_valid;
    logic             tgt_bit;
    logic             tgt_ready;
    logic             s;
    logic             r;
    logic             q_fb;
    logic             busy;
    logic             mismatch;
    logic [ERR_W-1:0] err_cnt;

    logic flop_q;
    bit   stuck;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    typedef struct {
        int drv;
        bit s;
        bit r;
        bit mis;
        int err;
    } exp_t;

    exp_t sbq[$];
    exp_t chkq[$];
    int   pend_pop[$];
    exp_t mon_e;

    bit m_cur;
    bit m_flop;
    int m_err;
    int last_drv;
    bit saw_not_ready;
    int d;
    int target;
    int drv3;

    sr_flipflop_driver #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid),
        .tgt_bit   (tgt_bit),
        .tgt_ready (tgt_ready),
        .s         (s),
        .r         (r),
        .q_fb      (q_fb),
        .busy      (busy),
        .mismatch  (mismatch),
        .err_cnt   (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Attached SR flop, sharing rst with the driver.
    always @(posedge clk or posedge rst) begin
        if (rst)    flop_q <= 1'b0;
        else if (s) flop_q <= 1'b1;
        else if (r) flop_q <= 1'b0;
    end
    assign q_fb = stuck ? 1'b0 : flop_q;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_excite(input bit cur, input bit tgt, output bit es, output bit er);
`ifdef SR_FORCE_EXCITE_EN
        es = tgt;
        er = !tgt;
`else
        es = tgt && !cur;
        er = !tgt && cur;
`endif
    endfunction

    task automatic model_reset();
        m_cur    = 1'b0;
        m_flop   = 1'b0;
        m_err    = 0;
        last_drv = -100;
        sbq.delete();
        chkq.delete();
        pend_pop.delete();
    endtask

    // Item pushed at edge p drives one cycle later, or two cycles after the previous drive.
    task automatic accept(input bit b, input int p, output int dr);
        bit   es, er, qv, mis;
        exp_t e;
        dr = (p + 1 > last_drv + 2) ? p + 1 : last_drv + 2;
        last_drv = dr;
        pend_pop.push_back(dr);
        model_excite(m_cur, b, es, er);
        if (es)      m_flop = 1'b1;
        else if (er) m_flop = 1'b0;
        qv  = stuck ? 1'b0 : m_flop;
        mis = (qv != b);
        if (mis) begin
            if (m_err < ERR_MAX) m_err++;
            m_cur = qv;
        end else begin
            m_cur = b;
        end
        e.drv = dr;
        e.s   = es;
        e.r   = er;
        e.mis = mis;
        e.err = m_err;
        sbq.push_back(e);
    endtask

    // Called and returns at a falling edge.
    task automatic send(input bit b, input int max_gap, output int dr);
        dr = -1;
        if (max_gap > 0) begin
            tgt_valid = 1'b0;
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        end
        tgt_valid = 1'b1;
        tgt_bit   = b;
        for (int tries = 0; tries < 64; tries++) begin
            while (pend_pop.size() > 0 && pend_pop[0] <= cyc) void'(pend_pop.pop_front());
            chk("tgt_ready", int'(tgt_ready), int'(pend_pop.size() < DEPTH));
            if (!tgt_ready) saw_not_ready = 1'b1;
            if (tgt_ready) begin
                accept(b, cyc + 1, dr);
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        chk("push_timeout", 0, 1);
    endtask

    task automatic drain();
        int k;
        tgt_valid = 1'b0;
        for (k = 0; k < 4000 && (sbq.size() > 0 || chkq.size() > 0); k++) @(negedge clk);
        if (sbq.size() > 0 || chkq.size() > 0) begin
            chk("drain_timeout", sbq.size() + chkq.size(), 0);
            sbq.delete();
            chkq.delete();
        end
        repeat (2) @(negedge clk);
        chk("busy_idle", int'(busy), 0);
    endtask

    // Monitor: compares excitation at predicted drive cycles and the check result two cycles later.
    always @(negedge clk) begin
        if (!rst) begin
            chk("s_r_exclusive", int'(s && r), 0);
            if (sbq.size() > 0 && sbq[0].drv < cyc) begin
                chk("drive_missed", cyc, sbq[0].drv);
                void'(sbq.pop_front());
            end
            if (sbq.size() > 0 && sbq[0].drv == cyc) begin
                mon_e = sbq.pop_front();
                chk("drive_s", int'(s), int'(mon_e.s));
                chk("drive_r", int'(r), int'(mon_e.r));
                chkq.push_back(mon_e);
            end else begin
                chk("idle_sr", int'({s, r}), 0);
            end
            if (chkq.size() > 0 && chkq[0].drv + 2 == cyc) begin
                mon_e = chkq.pop_front();
                chk("mismatch", int'(mismatch), int'(mon_e.mis));
                chk("err_cnt", int'(err_cnt), mon_e.err);
            end else begin
                chk("no_mismatch", int'(mismatch), 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        tgt_valid = 1'b0;
        tgt_bit   = 1'b0;
        stuck     = 1'b0;
        saw_not_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_s", int'(s), 0);
        chk("rst_r", int'(r), 0);
        chk("rst_mismatch", int'(mismatch), 0);
        chk("rst_err", int'(err_cnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(tgt_ready), 1);
        rst = 1'b0;

        // Basic sequence through a real flop.
        send(1'b1, 0, d);
        send(1'b0, 0, d);
        send(1'b0, 0, d);
        send(1'b1, 0, d);
        drain();
        chk("t1_qfb", int'(q_fb), 1);
        chk("t1_err", int'(err_cnt), 0);

        // Back-to-back pushes until the FIFO fills.
        saw_not_ready = 1'b0;
        for (int i = 0; i < 10; i++) send(1'($urandom_range(1, 0)), 0, d);
        drain();
        chk("t2_ready_fell", int'(saw_not_ready), 1);

        // Stuck-low feedback: mismatches and resync.
        stuck = 1'b1;
        send(1'b1, 0, d);
        drain();
        send(1'b1, 0, d);
        drain();

        // Saturation of the error counter.
        for (int i = 0; i < 520; i++) send(1'(i % 2 == 0), 0, d);
        drain();
        chk("t4_saturate", int'(err_cnt), ERR_MAX);
        stuck = 1'b0;

        // Reset during a DRIVE cycle with bits still queued.
        for (int i = 0; i < 6; i++) begin
            send(1'(i % 2 == 0), 0, d);
            if (i == 2) drv3 = d;
        end
        tgt_valid = 1'b0;
        target = drv3;
        while (cyc < target) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_s", int'(s), 0);
        chk("midrst_r", int'(r), 0);
        chk("midrst_ready", int'(tgt_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_err", int'(err_cnt), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_busy", int'(busy), 0);
        end

        // Hold case: excitation depends on the build option.
        send(1'b1, 0, d);
        send(1'b1, 0, d);
        drain();
        chk("t6_err", int'(err_cnt), 0);

        // Randomized traffic with gaps.
        for (int i = 0; i < 60; i++) send(1'($urandom_range(1, 0)), 3, d);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
